multi_grant_rr_allocator: RTL and testbench

//   Registered N-way request allocator. Each accepted cycle it selects up to GRANT_N

---
 rtl/multi_grant_rr_allocator_if.sv | 43 ++++
 rtl/multi_grant_rr_allocator.sv | 164 ++++++++++++++++
 tb/tb_multi_grant_rr_allocator.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/multi_grant_rr_allocator_if.sv
// ---------------------------------------------------------------------------
// multi_grant_rr_allocator_if
//   Bundles the request side and the grant side of the multi-grant allocator.
//   master : the environment (request sources + consumer)
//   slave  : the allocator itself
// Signals
//   i_req        REQ_N          level request vector, bit k = requester k
//   i_ready      1              consumer accepts the current grant set
//   o_grant_idx  GRANT_N*OUT_N  slot s index at [s*OUT_N +: OUT_N]
//   o_grant_vld  GRANT_N        slot s holds a valid grant
//   o_grant_mask REQ_N          OR of one-hot(idx) over valid slots
//   o_valid      1              any slot valid
// ---------------------------------------------------------------------------
interface multi_grant_rr_allocator_if #(
   parameter int REQ_N   = 12,
   parameter int GRANT_N = 2,
   parameter int OUT_N   = $clog2(REQ_N)
);
   logic [REQ_N-1:0]         i_req;
   logic                     i_ready;
   logic [GRANT_N*OUT_N-1:0] o_grant_idx;
   logic [GRANT_N-1:0]       o_grant_vld;
   logic [REQ_N-1:0]         o_grant_mask;
   logic                     o_valid;

   modport master (
      output i_req,
      output i_ready,
      input  o_grant_idx,
      input  o_grant_vld,
      input  o_grant_mask,
      input  o_valid
   );

   modport slave (
      input  i_req,
      input  i_ready,
      output o_grant_idx,
      output o_grant_vld,
      output o_grant_mask,
      output o_valid
   );
endinterface

// File: rtl/multi_grant_rr_allocator.sv
// ---------------------------------------------------------------------------
// multi_grant_rr_allocator
//   Registered allocator: on every load cycle (no grant held, or the consumer
//   accepts the held one) it picks up to GRANT_N distinct active requesters,
//   scanning from a rotating pointer (RR_EN=1) or from index 0 (RR_EN=0).
//   While a grant set is held and not accepted, everything is frozen.
// Ports
//   i_clk    clock, rising edge
//   i_rst_n  asynchronous active-low reset
//   bus      allocator side (slave modport) of multi_grant_rr_allocator_if
// ---------------------------------------------------------------------------
module multi_grant_rr_allocator #(
   parameter int REQ_N   = 12,
   parameter int GRANT_N = 2,
   parameter int RR_EN   = 1,
   parameter int OUT_N   = $clog2(REQ_N)
) (
   input  logic                        i_clk,
   input  logic                        i_rst_n,
   multi_grant_rr_allocator_if.slave   bus
);

   if (REQ_N < 2 || GRANT_N < 1 || GRANT_N > REQ_N) begin : g_bad_param
      $error("multi_grant_rr_allocator: illegal REQ_N/GRANT_N combination");
   end

   // One extra bit so start+offset can be range-reduced without overflow.
   localparam logic [OUT_N:0]   REQ_N_X  = (OUT_N+1)'(REQ_N);
   localparam logic [OUT_N-1:0] LAST_IDX = OUT_N'(REQ_N - 1);

   logic [OUT_N-1:0]         ptr_q, ptr_d;
   logic [GRANT_N*OUT_N-1:0] idx_q, idx_d;
   logic [GRANT_N-1:0]       vld_q, vld_d;
   logic [REQ_N-1:0]         mask_q, mask_d;
   logic                     valid_q, valid_d;

   logic                     load_s;
   logic [OUT_N-1:0]         start_s;
   logic [OUT_N:0]           pos_s;
   logic [REQ_N-1:0]         rot_s;
   logic [REQ_N-1:0]         remain_s;
   logic                     found_s;
   logic [OUT_N-1:0]         sel_k_s;
   logic [OUT_N:0]           sum_s;
   logic [OUT_N-1:0]         idx_s;
   logic [OUT_N-1:0]         last_idx_s;
   logic [GRANT_N*OUT_N-1:0] sel_idx_s;
   logic [GRANT_N-1:0]       sel_vld_s;
   logic [REQ_N-1:0]         sel_mask_s;
   logic [OUT_N-1:0]         sel_ptr_s;

   // Rotate the request vector so that bit 0 is the first requester scanned.
   always_comb begin
      start_s = (RR_EN != 0) ? ptr_q : '0;
      rot_s   = '0;
      pos_s   = '0;
      for (int k = 0; k < REQ_N; k++) begin
         pos_s = {1'b0, start_s} + (OUT_N+1)'(k);
         if (pos_s >= REQ_N_X) begin
            pos_s = pos_s - REQ_N_X;
         end else begin
            pos_s = pos_s;
         end
         rot_s[k] = bus.i_req[pos_s[OUT_N-1:0]];
      end
   end

   // Cascaded search: each stage takes the lowest remaining rotated bit and
   // removes it, so later slots can never repeat an earlier index.
   always_comb begin
      remain_s   = rot_s;
      found_s    = 1'b0;
      sel_k_s    = '0;
      sum_s      = '0;
      idx_s      = '0;
      last_idx_s = '0;
      sel_idx_s  = '0;
      sel_vld_s  = '0;
      sel_mask_s = '0;
      for (int s = 0; s < GRANT_N; s++) begin
         found_s = 1'b0;
         sel_k_s = '0;
         // Descending scan so the lowest set bit is the one that sticks.
         for (int k = REQ_N - 1; k >= 0; k--) begin
            if (remain_s[k]) begin
               found_s = 1'b1;
               sel_k_s = OUT_N'(k);
            end else begin
               found_s = found_s;
            end
         end
         if (found_s) begin
            remain_s[sel_k_s] = 1'b0;
            sum_s = {1'b0, start_s} + {1'b0, sel_k_s};
            if (sum_s >= REQ_N_X) begin
               sum_s = sum_s - REQ_N_X;
            end else begin
               sum_s = sum_s;
            end
            idx_s                          = sum_s[OUT_N-1:0];
            sel_vld_s[s]                   = 1'b1;
            sel_idx_s[s*OUT_N +: OUT_N]    = idx_s;
            sel_mask_s[idx_s]              = 1'b1;
            last_idx_s                     = idx_s;
         end else begin
            remain_s = remain_s;
         end
      end

      // Explicit wrap keeps ptr below REQ_N for non-power-of-2 sizes.
      if (RR_EN == 0) begin
         sel_ptr_s = '0;
      end else if (|sel_vld_s) begin
         if (last_idx_s == LAST_IDX) begin
            sel_ptr_s = '0;
         end else begin
            sel_ptr_s = last_idx_s + OUT_N'(1);
         end
      end else begin
         sel_ptr_s = ptr_q;
      end
   end

   // Next-state: take the new selection on a load cycle, otherwise hold.
   always_comb begin
      load_s = !valid_q || bus.i_ready;
      if (load_s) begin
         idx_d   = sel_idx_s;
         vld_d   = sel_vld_s;
         mask_d  = sel_mask_s;
         valid_d = |sel_vld_s;
         ptr_d   = sel_ptr_s;
      end else begin
         idx_d   = idx_q;
         vld_d   = vld_q;
         mask_d  = mask_q;
         valid_d = valid_q;
         ptr_d   = ptr_q;
      end
   end

   // State and output registers.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         idx_q   <= '0;
         vld_q   <= '0;
         mask_q  <= '0;
         valid_q <= 1'b0;
         ptr_q   <= '0;
      end else begin
         idx_q   <= idx_d;
         vld_q   <= vld_d;
         mask_q  <= mask_d;
         valid_q <= valid_d;
         ptr_q   <= ptr_d;
      end
   end

   assign bus.o_grant_idx  = idx_q;
   assign bus.o_grant_vld  = vld_q;
   assign bus.o_grant_mask = mask_q;
   assign bus.o_valid      = valid_q;

endmodule

// File: tb/tb_multi_grant_rr_allocator.sv
// ---------------------------------------------------------------------------
// tb_multi_grant_rr_allocator
//   Bench for multi_grant_rr_allocator with REQ_N=12, GRANT_N=2. One instance
//   runs round-robin, a second runs fixed priority. Expected grant sets are
//   queued when stimulus is driven and popped once the registered result
//   is visible.
// ---------------------------------------------------------------------------
module tb_multi_grant_rr_allocator;
   localparam int REQ_N   = 12;
   localparam int GRANT_N = 2;
   localparam int OUT_N   = 4;

   typedef struct packed {
      logic [1:0]  vld;
      logic [7:0]  idx;
      logic [11:0] mask;
      logic        valid;
      logic [3:0]  ptr;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;
   exp_t sb_q[$];
   exp_t sb_fp_q[$];

   always #5 clk = ~clk;

   multi_grant_rr_allocator_if #(.REQ_N(REQ_N), .GRANT_N(GRANT_N)) rr_if ();
   multi_grant_rr_allocator_if #(.REQ_N(REQ_N), .GRANT_N(GRANT_N)) fp_if ();

   multi_grant_rr_allocator #(.REQ_N(REQ_N), .GRANT_N(GRANT_N), .RR_EN(1)) dut_rr (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (rr_if.slave)
   );

   multi_grant_rr_allocator #(.REQ_N(REQ_N), .GRANT_N(GRANT_N), .RR_EN(0)) dut_fp (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (fp_if.slave)
   );

   // Expected record from slot valids, slot indices and pointer.
   function automatic exp_t mk(input logic [1:0] v, input logic [3:0] i0,
                               input logic [3:0] i1, input logic [3:0] p);
      exp_t e;
      e.vld  = v;
      e.idx  = {(v[1] ? i1 : 4'd0), (v[0] ? i0 : 4'd0)};
      e.mask = 12'h000;
      if (v[0]) e.mask[i0] = 1'b1;
      if (v[1]) e.mask[i1] = 1'b1;
      e.valid = |v;
      e.ptr   = p;
      return e;
   endfunction

   function automatic exp_t obs_rr();
      return {rr_if.o_grant_vld, rr_if.o_grant_idx, rr_if.o_grant_mask,
              rr_if.o_valid, dut_rr.ptr_q};
   endfunction

   function automatic exp_t obs_fp();
      return {fp_if.o_grant_vld, fp_if.o_grant_idx, fp_if.o_grant_mask,
              fp_if.o_valid, dut_fp.ptr_q};
   endfunction

   task automatic do_reset();
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      exp_t e, o;
      rst_n = 1'b0;
      rr_if.i_req = 12'h000; rr_if.i_ready = 1'b1;
      fp_if.i_req = 12'h000; fp_if.i_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      sb_q.push_back(mk(2'b00, 4'd0, 4'd0, 4'd0));
      e = sb_q.pop_front(); o = obs_rr(); checks++;
      if (o !== e) begin
         errors++;
         $display("FAIL reset_state: got %h expected %h", o, e);
      end
      rst_n = 1'b1;
      rr_if.i_req = 12'hFFF;
      sb_q.push_back(mk(2'b11, 4'd0, 4'd1, 4'd2));
      @(posedge clk); #1;
      e = sb_q.pop_front(); o = obs_rr(); checks++;
      if (o !== e) begin
         errors++;
         $display("FAIL reset_first_load: got %h expected %h", o, e);
      end
      // Reset asserted mid-cycle while a grant is held must clear at once.
      rr_if.i_ready = 1'b0;
      #3;
      rst_n = 1'b0;
      sb_q.push_back(mk(2'b00, 4'd0, 4'd0, 4'd0));
      #1;
      e = sb_q.pop_front(); o = obs_rr(); checks++;
      if (o !== e) begin
         errors++;
         $display("FAIL reset_async_clear: got %h expected %h", o, e);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      rr_if.i_ready = 1'b1;
      sb_q.push_back(mk(2'b11, 4'd0, 4'd1, 4'd2));
      @(posedge clk); #1;
      e = sb_q.pop_front(); o = obs_rr(); checks++;
      if (o !== e) begin
         errors++;
         $display("FAIL reset_release_load: got %h expected %h", o, e);
      end
   endtask

   task automatic test_rotation();
      exp_t e, o;
      do_reset();
      rr_if.i_req = 12'h0A6; rr_if.i_ready = 1'b1;
      sb_q.push_back(mk(2'b11, 4'd1, 4'd2, 4'd3));
      sb_q.push_back(mk(2'b11, 4'd5, 4'd7, 4'd8));
      sb_q.push_back(mk(2'b11, 4'd1, 4'd2, 4'd3));
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         e = sb_q.pop_front(); o = obs_rr(); checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL rotation[%0d]: got %h expected %h", i, o, e);
         end
      end
   endtask

   task automatic test_backpressure();
      exp_t e, o;
      rr_if.i_ready = 1'b0; rr_if.i_req = 12'h300;
      for (int i = 0; i < 3; i++) sb_q.push_back(mk(2'b11, 4'd1, 4'd2, 4'd3));
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         e = sb_q.pop_front(); o = obs_rr(); checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL backpressure_hold[%0d]: got %h expected %h", i, o, e);
         end
      end
      rr_if.i_ready = 1'b1;
      sb_q.push_back(mk(2'b11, 4'd8, 4'd9, 4'd10));
      @(posedge clk); #1;
      e = sb_q.pop_front(); o = obs_rr(); checks++;
      if (o !== e) begin
         errors++;
         $display("FAIL backpressure_release: got %h expected %h", o, e);
      end
   endtask

   task automatic test_wrap();
      exp_t e, o;
      rr_if.i_req = 12'h400;
      sb_q.push_back(mk(2'b01, 4'd10, 4'd0, 4'd11));
      @(posedge clk); #1;
      rr_if.i_req = 12'h801;
      sb_q.push_back(mk(2'b11, 4'd11, 4'd0, 4'd1));
      e = sb_q.pop_front(); o = obs_rr(); checks++;
      if (o !== e) begin
         errors++;
         $display("FAIL wrap_setup: got %h expected %h", o, e);
      end
      @(posedge clk); #1;
      e = sb_q.pop_front(); o = obs_rr(); checks++;
      if (o !== e) begin
         errors++;
         $display("FAIL wrap: got %h expected %h", o, e);
      end
   endtask

   task automatic test_partial_empty();
      exp_t e, o;
      rr_if.i_req = 12'h010;
      sb_q.push_back(mk(2'b01, 4'd4, 4'd0, 4'd5));
      sb_q.push_back(mk(2'b00, 4'd0, 4'd0, 4'd5));
      // With nothing held, i_ready low must not block the next load.
      sb_q.push_back(mk(2'b11, 4'd5, 4'd7, 4'd8));
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         if (i == 0) begin
            rr_if.i_req = 12'h000;
         end else begin
            rr_if.i_req = 12'h0A6; rr_if.i_ready = 1'b0;
         end
         e = sb_q.pop_front(); o = obs_rr(); checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL partial_empty[%0d]: got %h expected %h", i, o, e);
         end
      end
      rr_if.i_ready = 1'b1;
   endtask

   task automatic test_fixed_priority();
      exp_t e, o;
      fp_if.i_req = 12'h0A6; fp_if.i_ready = 1'b1;
      for (int i = 0; i < 3; i++) sb_fp_q.push_back(mk(2'b11, 4'd1, 4'd2, 4'd0));
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         e = sb_fp_q.pop_front(); o = obs_fp(); checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL fixed_priority[%0d]: got %h expected %h", i, o, e);
         end
      end
   endtask

   initial begin
      test_reset();
      test_rotation();
      test_backpressure();
      test_wrap();
      test_partial_empty();
      test_fixed_priority();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
